// File: rtl/keccak_round_scheduler_pkg.sv
// Shared definitions for the Keccak-f round scheduler: state encoding,
// step-unit indices and default permutation geometry.
package keccak_pkg;

    localparam int DEF_NUM_ROUNDS = 24;
    localparam int DEF_NUM_STEPS  = 5;

    localparam int STEP_THETA = 0;
    localparam int STEP_RHO   = 1;
    localparam int STEP_PI    = 2;
    localparam int STEP_CHI   = 3;
    localparam int STEP_IOTA  = 4;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_LOAD       = 4'd1,
        S_LOAD_WAIT  = 4'd2,
        S_STEP_START = 4'd3,
        S_STEP_WAIT  = 4'd4,
        S_ADVANCE    = 4'd5,
        S_DRAIN      = 4'd6,
        S_DRAIN_WAIT = 4'd7,
        S_DONE       = 4'd8
    } schedState_t;

endpackage

// File: rtl/keccak_round_scheduler_if.sv
// Handshake bundle between the round scheduler (master) and the
// load/step/drain units plus the requester (slave).
interface keccak_round_scheduler_if #(
    parameter int NUM_STEPS = 5,
    parameter int STP_W     = 3,
    parameter int RND_W     = 5
);
    logic                 start;
    logic                 ready;
    logic                 busy;
    logic                 loadStart;
    logic                 loadDone;
    logic [NUM_STEPS-1:0] stepStart;
    logic [NUM_STEPS-1:0] stepDone;
    logic [STP_W-1:0]     stepIdx;
    logic [RND_W-1:0]     roundIdx;
    logic                 bufSel;
    logic                 drainStart;
    logic                 drainDone;
    logic                 done;
    logic                 err;

    modport master (
        input  start, loadDone, stepDone, drainDone,
        output ready, busy, loadStart, stepStart, stepIdx, roundIdx,
               bufSel, drainStart, done, err
    );

    modport slave (
        output start, loadDone, stepDone, drainDone,
        input  ready, busy, loadStart, stepStart, stepIdx, roundIdx,
               bufSel, drainStart, done, err
    );

endinterface

// File: rtl/keccak_round_scheduler_counter.sv
// Nested step/round counter: steps wrap into the next round, and the
// pair saturates at the final step of the final round.
module round_step_counter #(
    parameter int NUM_ROUNDS = 24,
    parameter int NUM_STEPS  = 5,
    parameter int RND_W      = 5,
    parameter int STP_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [STP_W-1:0] stepIdx,
    output logic [RND_W-1:0] roundIdx,
    output logic             stepLast,
    output logic             roundLast
);

    assign stepLast  = (stepIdx == STP_W'(NUM_STEPS - 1));
    assign roundLast = (roundIdx == RND_W'(NUM_ROUNDS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stepIdx  <= '0;
            roundIdx <= '0;
        end else if (clear) begin
            stepIdx  <= '0;
            roundIdx <= '0;
        end else if (enable) begin
            if (!stepLast) begin
                stepIdx <= stepIdx + STP_W'(1);
            end else if (!roundLast) begin
                stepIdx  <= '0;
                roundIdx <= roundIdx + RND_W'(1);
            end
        end
    end

endmodule

// File: rtl/keccak_round_scheduler.sv
// Keccak-f sequencer: load, NUM_ROUNDS x NUM_STEPS step launches with
// ping-pong buffer toggling, then drain; all outputs are Moore decoded.
module keccak_round_scheduler
    import keccak_pkg::*;
#(
    parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
    parameter int NUM_STEPS  = DEF_NUM_STEPS,
    parameter int RND_W      = 5,
    parameter int STP_W      = 3
) (
    input logic                      clk,
    input logic                      rst,
    keccak_round_scheduler_if.master bus
);

    schedState_t          state, nextState;
    logic [STP_W-1:0]     stepIdx;
    logic [RND_W-1:0]     roundIdx;
    logic                 stepLast, roundLast;
    logic                 cntClear, cntEn;
    logic [NUM_STEPS-1:0] stepMask;
    logic                 strayStep, errSet;
    logic                 bufSel, err;

    round_step_counter #(
        .NUM_ROUNDS(NUM_ROUNDS),
        .NUM_STEPS (NUM_STEPS),
        .RND_W     (RND_W),
        .STP_W     (STP_W)
    ) uCounter (
        .clk      (clk),
        .rst      (rst),
        .clear    (cntClear),
        .enable   (cntEn),
        .stepIdx  (stepIdx),
        .roundIdx (roundIdx),
        .stepLast (stepLast),
        .roundLast(roundLast)
    );

    always_comb begin
        stepMask = '0;
        for (int unsigned i = 0; i < NUM_STEPS; i++) begin
            stepMask[i] = (stepIdx == STP_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nextState;
    end

    always_comb begin
        nextState = state;
        cntClear  = 1'b0;
        cntEn     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    cntClear  = 1'b1;
                    nextState = S_LOAD;
                end
            end
            S_LOAD:       nextState = S_LOAD_WAIT;
            S_LOAD_WAIT:  if (bus.loadDone) nextState = S_STEP_START;
            S_STEP_START: nextState = S_STEP_WAIT;
            S_STEP_WAIT:  if (|(bus.stepDone & stepMask)) nextState = S_ADVANCE;
            S_ADVANCE: begin
                cntEn     = 1'b1;
                nextState = (stepLast && roundLast) ? S_DRAIN : S_STEP_START;
            end
            S_DRAIN:      nextState = S_DRAIN_WAIT;
            S_DRAIN_WAIT: if (bus.drainDone) nextState = S_DONE;
            S_DONE:       nextState = S_IDLE;
            default:      nextState = S_IDLE;
        endcase
    end

    // Only the active unit may complete in StepWait; any done pulse arriving
    // while its unit is not being waited on is a protocol error (Idle excepted).
    always_comb begin
        strayStep = (state == S_STEP_WAIT) ? |(bus.stepDone & ~stepMask) : |bus.stepDone;
        errSet    = (state != S_IDLE) &&
                    (strayStep ||
                     (bus.loadDone  && (state != S_LOAD_WAIT)) ||
                     (bus.drainDone && (state != S_DRAIN_WAIT)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err    <= 1'b0;
            bufSel <= 1'b0;
        end else if (cntClear) begin
            err    <= 1'b0;
            bufSel <= 1'b0;
        end else begin
            if (errSet) err <= 1'b1;
            if (state == S_ADVANCE) bufSel <= ~bufSel;
        end
    end

    assign bus.ready      = (state == S_IDLE);
    assign bus.busy       = (state != S_IDLE);
    assign bus.loadStart  = (state == S_LOAD);
    assign bus.stepStart  = (state == S_STEP_START) ? stepMask : '0;
    assign bus.stepIdx    = stepIdx;
    assign bus.roundIdx   = roundIdx;
    assign bus.bufSel     = bufSel;
    assign bus.drainStart = (state == S_DRAIN);
    assign bus.done       = (state == S_DONE);
    assign bus.err        = err;

endmodule

// File: tb/tb_keccak_round_scheduler.sv
// Self-checking bench: a 24-round instance (vector table, resets, full run)
// and a 2-round instance (random handshake delays with an injected wrong done).
module tb_keccak_round_scheduler;

    localparam int NS  = 5;
    localparam int NRA = 24;
    localparam int NRB = 2;
    localparam logic [31:0] RST_OUT = 32'h0008_0000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    keccak_round_scheduler_if #(.NUM_STEPS(NS), .STP_W(3), .RND_W(5)) busA ();
    keccak_round_scheduler_if #(.NUM_STEPS(NS), .STP_W(3), .RND_W(5)) busB ();

    keccak_round_scheduler #(.NUM_ROUNDS(NRA), .NUM_STEPS(NS), .RND_W(5), .STP_W(3)) dutA (
        .clk(clk), .rst(rst), .bus(busA.master)
    );
    keccak_round_scheduler #(.NUM_ROUNDS(NRB), .NUM_STEPS(NS), .RND_W(5), .STP_W(3)) dutB (
        .clk(clk), .rst(rst), .bus(busB.master)
    );

    typedef struct {
        logic        start;
        logic        loadDone;
        logic [4:0]  stepDone;
        logic        drainDone;
        logic [31:0] expOut;
    } vec_t;

    vec_t tbl[13];

    int aLoadCnt, aStepCnt, aDrainCnt;
    logic [4:0] aStepBit;
    int bLoadCnt, bStepCnt, bDrainCnt, bInjCnt;
    logic [4:0] bStepBit;
    int edges, expStep, expRound, toggles, prevEdge, prevDelay, d;
    logic lastBuf, gotDone, found, havePrev, inj;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic rdy, bsy, ls, input logic [4:0] ss,
                                       input logic [2:0] si, input logic [4:0] ri,
                                       input logic bs, ds, dn, er);
        return {12'd0, rdy, bsy, ls, ss, si, ri, bs, ds, dn, er};
    endfunction

    function automatic logic [31:0] outsA();
        return {12'd0, busA.ready, busA.busy, busA.loadStart, busA.stepStart, busA.stepIdx,
                busA.roundIdx, busA.bufSel, busA.drainStart, busA.done, busA.err};
    endfunction

    function automatic vec_t mkRow(input logic s, ld, input logic [4:0] sd, input logic dd,
                                   input logic [31:0] e);
        vec_t r;
        r.start = s; r.loadDone = ld; r.stepDone = sd; r.drainDone = dd; r.expOut = e;
        return r;
    endfunction

    function automatic logic [4:0] onehot5(input int s);
        logic [4:0] r;
        r = 5'b00001 << s;
        return r;
    endfunction

    task automatic respA();
        busA.loadDone = 1'b0; busA.stepDone = '0; busA.drainDone = 1'b0;
        if (aLoadCnt > 0)  begin aLoadCnt--;  if (aLoadCnt == 0)  busA.loadDone = 1'b1; end
        if (aStepCnt > 0)  begin aStepCnt--;  if (aStepCnt == 0)  busA.stepDone = aStepBit; end
        if (aDrainCnt > 0) begin aDrainCnt--; if (aDrainCnt == 0) busA.drainDone = 1'b1; end
        if (busA.loadStart) aLoadCnt = 1;
        if (busA.stepStart != '0) begin aStepCnt = 1; aStepBit = busA.stepStart; end
        if (busA.drainStart) aDrainCnt = 1;
    endtask

    task automatic respB();
        busB.loadDone = 1'b0; busB.stepDone = '0; busB.drainDone = 1'b0;
        if (bLoadCnt > 0)  begin bLoadCnt--;  if (bLoadCnt == 0)  busB.loadDone = 1'b1; end
        if (bStepCnt > 0)  begin bStepCnt--;  if (bStepCnt == 0)  busB.stepDone = bStepBit; end
        if (bInjCnt > 0)   begin bInjCnt--;   if (bInjCnt == 0)   busB.stepDone[3] = 1'b1; end
        if (bDrainCnt > 0) begin bDrainCnt--; if (bDrainCnt == 0) busB.drainDone = 1'b1; end
        if (busB.loadStart)  bLoadCnt  = 1 + int'($urandom_range(0, 10));
        if (busB.drainStart) bDrainCnt = 1 + int'($urandom_range(0, 10));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        busA.start = 1'b0; busA.loadDone = 1'b0; busA.stepDone = '0; busA.drainDone = 1'b0;
        busB.start = 1'b0; busB.loadDone = 1'b0; busB.stepDone = '0; busB.drainDone = 1'b0;
        aLoadCnt = 0; aStepCnt = 0; aDrainCnt = 0; aStepBit = '0;
        bLoadCnt = 0; bStepCnt = 0; bDrainCnt = 0; bInjCnt = 0; bStepBit = '0;

        //             start ld  stepDone  dd   rdy bsy ls stepStart si  ri  bs ds dn er
        tbl[0]  = mkRow(1, 0, 5'b00000, 0, pk(1, 0, 0, 5'b00000, 0, 0, 0, 0, 0, 0));
        tbl[1]  = mkRow(1, 0, 5'b00000, 0, pk(0, 1, 1, 5'b00000, 0, 0, 0, 0, 0, 0));
        tbl[2]  = mkRow(1, 0, 5'b00000, 0, pk(0, 1, 0, 5'b00000, 0, 0, 0, 0, 0, 0));
        tbl[3]  = mkRow(0, 1, 5'b00000, 0, pk(0, 1, 0, 5'b00000, 0, 0, 0, 0, 0, 0));
        tbl[4]  = mkRow(0, 0, 5'b00000, 0, pk(0, 1, 0, 5'b00001, 0, 0, 0, 0, 0, 0));
        tbl[5]  = mkRow(1, 0, 5'b00001, 0, pk(0, 1, 0, 5'b00000, 0, 0, 0, 0, 0, 0));
        tbl[6]  = mkRow(0, 0, 5'b00000, 0, pk(0, 1, 0, 5'b00000, 0, 0, 0, 0, 0, 0));
        tbl[7]  = mkRow(0, 0, 5'b00000, 0, pk(0, 1, 0, 5'b00010, 1, 0, 1, 0, 0, 0));
        tbl[8]  = mkRow(0, 0, 5'b01000, 0, pk(0, 1, 0, 5'b00000, 1, 0, 1, 0, 0, 0));
        tbl[9]  = mkRow(0, 0, 5'b00000, 0, pk(0, 1, 0, 5'b00000, 1, 0, 1, 0, 0, 1));
        tbl[10] = mkRow(0, 0, 5'b00010, 0, pk(0, 1, 0, 5'b00000, 1, 0, 1, 0, 0, 1));
        tbl[11] = mkRow(0, 0, 5'b00000, 0, pk(0, 1, 0, 5'b00000, 1, 0, 1, 0, 0, 1));
        tbl[12] = mkRow(0, 0, 5'b00000, 0, pk(0, 1, 0, 5'b00100, 2, 0, 0, 0, 0, 1));

        @(negedge clk);
        check("resetA", outsA(), RST_OUT);
        check("resetReadyB", busB.ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d", i), outsA(), tbl[i].expOut);
            busA.start     = tbl[i].start;
            busA.loadDone  = tbl[i].loadDone;
            busA.stepDone  = tbl[i].stepDone;
            busA.drainDone = tbl[i].drainDone;
        end

        // Asynchronous reset asserted mid-cycle, checked before the next edge
        @(negedge clk);
        busA.start = 1'b0; busA.loadDone = 1'b0; busA.stepDone = '0; busA.drainDone = 1'b0;
        #2 rst = 1'b1;
        #1 check("asyncRst", outsA(), RST_OUT);
        @(negedge clk);
        rst = 1'b0;

        @(negedge clk);
        busA.drainDone = 1'b1;
        @(negedge clk);
        busA.drainDone = 1'b0;
        check("idleDrainErr", {busA.ready, busA.err}, 2'b10);

        @(negedge clk);
        busA.start = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 2000 && !found; c++) begin
            @(negedge clk);
            busA.start = 1'b0;
            if (busA.stepStart[2] && busA.roundIdx == 5'd7) found = 1'b1;
            else respA();
        end
        check("reachR7S2", found, 1'b1);
        @(negedge clk);
        check("midIdx", {busA.busy, busA.stepIdx, busA.roundIdx}, {1'b1, 3'd2, 5'd7});
        busA.drainDone = 1'b1;
        @(negedge clk);
        busA.drainDone = 1'b0;
        check("strayDrainErr", {busA.err, busA.stepIdx, busA.roundIdx}, {1'b1, 3'd2, 5'd7});
        #2 rst = 1'b1;
        #1 check("midRst", outsA(), RST_OUT);
        @(negedge clk);
        rst = 1'b0;
        aLoadCnt = 0; aStepCnt = 0; aDrainCnt = 0;

        @(negedge clk);
        busA.start = 1'b1;
        edges = 0; expStep = 0; expRound = 0; toggles = 0; lastBuf = busA.bufSel; gotDone = 1'b0;
        while (!gotDone && edges < 2000) begin
            @(negedge clk);
            busA.start = 1'b0;
            edges++;
            if (busA.bufSel != lastBuf) toggles++;
            lastBuf = busA.bufSel;
            if (busA.stepStart != '0) begin
                check("orderA", {busA.stepStart, busA.stepIdx, busA.roundIdx},
                      {onehot5(expStep), 3'(expStep), 5'(expRound)});
                if (expStep == NS - 1) begin expStep = 0; expRound++; end
                else expStep++;
            end
            if (busA.done) gotDone = 1'b1;
            else respA();
        end
        check("doneSeenA", gotDone, 1'b1);
        check("latencyA", edges + 1, 2 + 1 + 3 * NS * NRA + 2 + 1);
        check("togglesA", toggles, NS * NRA);
        check("stepsA", expRound * NS + expStep, NS * NRA);
        check("finalA", {busA.bufSel, busA.roundIdx, busA.stepIdx, busA.err},
              {1'b0, 5'(NRA - 1), 3'(NS - 1), 1'b0});

        @(negedge clk);
        busB.start = 1'b1;
        edges = 0; expStep = 0; expRound = 0; havePrev = 1'b0; gotDone = 1'b0;
        while (!gotDone && edges < 1000) begin
            @(negedge clk);
            busB.start = 1'b0;
            edges++;
            if (busB.done) gotDone = 1'b1;
            else begin
                respB();
                if (busB.stepStart != '0) begin
                    check("orderB", {busB.stepStart, busB.stepIdx, busB.roundIdx},
                          {onehot5(expStep), 3'(expStep), 5'(expRound)});
                    if (havePrev) check("gapB", edges - prevEdge, prevDelay + 3);
                    inj = (expStep == 1 && expRound == 0);
                    d = inj ? 1 + int'($urandom_range(0, 9)) : int'($urandom_range(0, 10));
                    bStepCnt = d + 1;
                    bStepBit = busB.stepStart;
                    if (inj) bInjCnt = 1;
                    havePrev = 1'b1; prevEdge = edges; prevDelay = d;
                    if (expStep == NS - 1) begin expStep = 0; expRound++; end
                    else expStep++;
                end
            end
        end
        check("doneSeenB", gotDone, 1'b1);
        check("stepsB", expRound * NS + expStep, NS * NRB);
        check("finalB", {busB.bufSel, busB.roundIdx, busB.err}, {1'b0, 5'(NRB - 1), 1'b1});
        @(negedge clk);
        check("errStickyIdleB", {busB.ready, busB.err}, 2'b11);
        busB.start = 1'b1;
        @(negedge clk);
        busB.start = 1'b0;
        check("errClearB", {busB.loadStart, busB.err}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_round_scheduler.md
# keccak_round_scheduler

Top-level sequencer for the Keccak-f permutation datapath. It accepts a start request, runs the input-load phase, and then walks each round through the step units in fixed order (theta/column parity, rho, pi, chi, iota) for `NUM_ROUNDS` rounds. It starts exactly one step unit at a time and toggles the ping-pong state-buffer select after every step. It then runs the output-drain phase and reports completion. It sits above the per-step controllers and talks to them only through start/done pulse handshakes.

## Interface
- `NUM_ROUNDS`, default 24: rounds per permutation; must be ≥1.
- `NUM_STEPS`, default 5: step units per round; must be ≥1.
- `RND_W`, default 5: round-index width; must satisfy 2^RND_W ≥ NUM_ROUNDS.
- `STP_W`, default 3: step-index width; must satisfy 2^STP_W ≥ NUM_STEPS.

Ports:
- `clk`  in  1  clock, all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a permutation; sampled only in Idle.
- `ready`  out  1  high in Idle.
- `busy`  out  1  high in every state except Idle.
- `loadStart`  out  1  one-cycle pulse that launches the input-load unit.
- `loadDone`  in  1  pulse from the input-load unit when loading is finished.
- `stepStart`  out  NUM_STEPS  one-hot, one-cycle pulse to the active step unit.
- `stepDone`  in  NUM_STEPS  per-unit completion pulses.
- `stepIdx`  out  STP_W  index of the active step.
- `roundIdx`  out  RND_W  index of the current round; feeds the round-constant ROM.
- `bufSel`  out  1  ping-pong select: step reads buffer bufSel and writes buffer ~bufSel.
- `drainStart`  out  1  one-cycle pulse that launches the output unit.
- `drainDone`  in  1  pulse from the output unit when draining is finished.
- `done`  out  1  one-cycle pulse when the permutation is complete.
- `err`  out  1  sticky protocol-error flag; cleared only by reset or by an accepted start.

## Operation
Reset (async) state: Idle. Reset values: `stepIdx`=0, `roundIdx`=0, `bufSel`=0, `err`=0, `ready`=1. All other outputs are 0.

States and transitions:
- **Idle:** `ready`=1. If `start`=1: clear `stepIdx`, `roundIdx`, `bufSel` and `err`, then go to Load.
- **Load:** `loadStart`=1, then go to LoadWait.
- **LoadWait:** on `loadDone`=1 go to StepStart; otherwise stay.
- **StepStart:** `stepStart[stepIdx]`=1, then go to StepWait.
- **StepWait:**
  - `stepDone[stepIdx]`=1 → go to Advance.
  - Any other `stepDone` bit set, in this state or in any other non-Idle state → set `err`; the state is unaffected.
- **Advance:** toggle `bufSel`.
  - If `stepIdx` < NUM_STEPS-1: `stepIdx`++, go to StepStart.
  - Else if `roundIdx` < NUM_ROUNDS-1: `stepIdx`=0, `roundIdx`++, go to StepStart.
  - Else: go to Drain; `stepIdx` and `roundIdx` hold their final values.
- **Drain:** `drainStart`=1, then go to DrainWait.
- **DrainWait:** on `drainDone`=1 go to Done.
- **Done:** `done`=1, then go to Idle.

Further rules:
- `loadDone` or `drainDone` arriving outside its wait state sets `err` and is otherwise ignored.
- `start` outside Idle is ignored and does not set `err`.
- Counter wrap: `stepIdx` never exceeds NUM_STEPS-1 and `roundIdx` never exceeds NUM_ROUNDS-1.
- Reset mid-operation returns the block to Idle immediately, with no pulses emitted.

## Timing
- All outputs are Moore outputs, decoded from the registered state and counters only; there is no combinational input-to-output path.
- `stepIdx`, `roundIdx` and `bufSel` are stable from StepStart through StepWait.
- `bufSel` changes only on the edge leaving Advance.
- A done pulse seen in the same cycle that its wait state is entered counts: the FSM leaves the wait state on the next edge, giving a minimum of 3 cycles per step.
- Minimum total latency from the `start` edge to the `done` cycle: 2 + 1 + 3·NUM_STEPS·NUM_ROUNDS + 2 + 1 cycles, with every done pulse arriving on the first wait cycle. For 24/5 this is 366.
- Total number of `bufSel` toggles is NUM_STEPS·NUM_ROUNDS. With 120 toggles the final `bufSel` is 0.

## Structure
- Shared package `keccak_pkg`:
  - state encoding localparams (4-bit): Idle, Load, LoadWait, StepStart, StepWait, Advance, Drain, DrainWait, Done;
  - step index constants: STEP_THETA=0, STEP_RHO=1, STEP_PI=2, STEP_CHI=3, STEP_IOTA=4;
  - default NUM_ROUNDS and NUM_STEPS.
- One sub-module, `round_step_counter`: the nested step/round counter with clear, enable, `stepLast` and `roundLast` outputs. The FSM stays in the top module.

## Test plan
- **Reset values:** assert `rst` mid-cycle → all outputs return to reset values without waiting for a clock edge; `ready`=1.
- **Full run, immediate handshakes:** 24/5 with every done pulse returned in the first wait cycle → `done` exactly 366 cycles after the `start` edge; 120 `stepStart` pulses in order 0,1,2,3,4 repeated; `roundIdx` reaches 23; final `bufSel`=0.
- **Delayed and wrong done pulses:** NUM_ROUNDS=2 with random 0–10-cycle delays on each done pulse, plus `stepDone[3]` injected while `stepIdx`=1 → FSM holds in StepWait until `stepDone[1]`; `err`=1 and stays 1 until the next accepted start.
- **Start outside Idle:** pulse `start` during LoadWait and during StepWait → no restart, counters unchanged, `err`=0.
- **Reset mid-operation:** assert `rst` during StepWait at round 7, step 2 → block returns to Idle; a following start runs a full permutation with `roundIdx` starting at 0.
- **Stray drain/load done:** `drainDone` pulsed in Idle → `err` unchanged; `drainDone` pulsed in StepWait → `err`=1; the next `start` clears `err`.
